// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the bus: a first-word-fall-through FIFO
// of {error, data} entries with level, sticky overflow/underflow and a threshold interrupt.
module uart_rx_fifo #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDRW     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_done,
    input  logic [DATAWIDTH-1:0] rx_data,
    input  logic                 rx_error,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 clr_flags,
    input  logic [ADDRW:0]       thresh,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_error,
    output logic                 empty,
    output logic                 full,
    output logic [ADDRW:0]       level,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 irq
);

    localparam int unsigned LW = ADDRW + 1;
    localparam int unsigned EW = DATAWIDTH + 1;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [ADDRW-1:0] r_wr_ptr;
    logic [ADDRW-1:0] r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [EW-1:0]    r_head;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_irq;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_ovf_ev;
    logic             w_unf_ev;
    logic [ADDRW-1:0] w_wr_ptr_nxt;
    logic [ADDRW-1:0] w_rd_ptr_nxt;
    logic [LW-1:0]    w_level_nxt;
    logic [EW-1:0]    w_head_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));

    // Next-state: flush overrides push/pop and suppresses the flag events of that cycle.
    always_comb begin
        w_pop_ok     = pop && !w_empty && !flush;
        w_push_ok    = rx_done && !flush && (!w_full || w_pop_ok);
        w_ovf_ev     = rx_done && !flush && w_full && !w_pop_ok;
        w_unf_ev     = pop && !flush && w_empty;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_level_nxt  = r_level;
        if (flush) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_level_nxt  = '0;
        end else begin
            if (w_push_ok) w_wr_ptr_nxt = r_wr_ptr + ADDRW'(1);
            if (w_pop_ok)  w_rd_ptr_nxt = r_rd_ptr + ADDRW'(1);
            if (w_push_ok && !w_pop_ok)      w_level_nxt = r_level + LW'(1);
            else if (w_pop_ok && !w_push_ok) w_level_nxt = r_level - LW'(1);
        end
        // The byte written this cycle becomes the head when it lands on the next read slot.
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_nxt)) w_head_nxt = {rx_error, rx_data};
        else                                          w_head_nxt = r_mem[w_rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= {rx_error, rx_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_head      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            if (w_level_nxt != '0) r_head <= w_head_nxt;
            r_overflow  <= w_ovf_ev || (r_overflow && !clr_flags);
            r_underflow <= w_unf_ev || (r_underflow && !clr_flags);
            r_irq       <= (thresh != '0) && (w_level_nxt >= thresh);
        end
    end

    assign rd_data   = r_head[DATAWIDTH-1:0];
    assign rd_error  = r_head[DATAWIDTH];
    assign empty     = w_empty;
    assign full      = w_full;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign irq       = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed table-driven bench for uart_rx_fifo (DATAWIDTH=8, DEPTH=16) plus
// hand-written reset and mid-stream async reset sequences.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       pop;
    logic       flush;
    logic       clr_flags;
    logic [4:0] thresh;
    logic [7:0] rd_data;
    logic       rd_error;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       underflow;
    logic       irq;

    uart_rx_fifo #(.DATAWIDTH(8), .DEPTH(16), .ADDRW(4)) dut (
        .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
        .rx_error(rx_error), .pop(pop), .flush(flush), .clr_flags(clr_flags),
        .thresh(thresh), .rd_data(rd_data), .rd_error(rd_error), .empty(empty),
        .full(full), .level(level), .overflow(overflow), .underflow(underflow),
        .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       d;
        logic [7:0] dat;
        logic       er;
        logic       p;
        logic       fl;
        logic       cl;
        logic [4:0] thr;
        int         lvl;
        logic       chk;
        logic [7:0] edat;
        logic       eerr;
        logic       ovf;
        logic       unf;
        logic       eirq;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(string nm, logic d, logic [7:0] dat, logic er, logic p,
                                logic fl, logic cl, int thr, int lvl, logic chk,
                                logic [7:0] edat, logic eerr, logic ovf, logic unf, logic eirq);
        vec_t v;
        v.nm = nm; v.d = d; v.dat = dat; v.er = er; v.p = p; v.fl = fl; v.cl = cl;
        v.thr = 5'(thr); v.lvl = lvl; v.chk = chk; v.edat = edat; v.eerr = eerr;
        v.ovf = ovf; v.unf = unf; v.eirq = eirq;
        vq.push_back(v);
    endfunction

    task automatic cmp(string nm, string fld, logic [31:0] got, logic [31:0] exp);
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %0h expected %0h", nm, fld, got, exp);
        end
    endtask

    task automatic check_reset_state(string nm);
        n_vec++;
        cmp(nm, "level", 32'(level), 0);
        cmp(nm, "empty", 32'(empty), 1);
        cmp(nm, "full", 32'(full), 0);
        cmp(nm, "overflow", 32'(overflow), 0);
        cmp(nm, "underflow", 32'(underflow), 0);
        cmp(nm, "irq", 32'(irq), 0);
        cmp(nm, "rd_data", 32'(rd_data), 0);
        cmp(nm, "rd_error", 32'(rd_error), 0);
    endtask

    task automatic apply(vec_t v);
        @(negedge clk);
        rx_done = v.d; rx_data = v.dat; rx_error = v.er; pop = v.p;
        flush = v.fl; clr_flags = v.cl; thresh = v.thr;
        @(posedge clk);
        #1;
        n_vec++;
        cmp(v.nm, "level", 32'(level), 32'(v.lvl));
        cmp(v.nm, "empty", 32'(empty), 32'(v.lvl == 0));
        cmp(v.nm, "full", 32'(full), 32'(v.lvl == 16));
        cmp(v.nm, "overflow", 32'(overflow), 32'(v.ovf));
        cmp(v.nm, "underflow", 32'(underflow), 32'(v.unf));
        cmp(v.nm, "irq", 32'(irq), 32'(v.eirq));
        if (v.chk) begin
            cmp(v.nm, "rd_data", 32'(rd_data), 32'(v.edat));
            cmp(v.nm, "rd_error", 32'(rd_error), 32'(v.eerr));
        end
    endtask

    task automatic idle_inputs();
        rx_done = 0; rx_data = 0; rx_error = 0; pop = 0;
        flush = 0; clr_flags = 0; thresh = 0;
    endtask

    initial begin
        // In-order push/pop; pop on last entry holds the data.
        add("push41", 1, 8'h41, 0, 0, 0, 0, 0, 1, 1, 8'h41, 0, 0, 0, 0);
        add("push42", 1, 8'h42, 0, 0, 0, 0, 0, 2, 1, 8'h41, 0, 0, 0, 0);
        add("push43", 1, 8'h43, 0, 0, 0, 0, 0, 3, 1, 8'h41, 0, 0, 0, 0);
        add("pop1",   0, 8'h00, 0, 1, 0, 0, 0, 2, 1, 8'h42, 0, 0, 0, 0);
        add("pop2",   0, 8'h00, 0, 1, 0, 0, 0, 1, 1, 8'h43, 0, 0, 0, 0);
        add("pop3",   0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h43, 0, 0, 0, 0);
        // Fill, overflow, drain, clear.
        for (int i = 0; i < 16; i++)
            add("fill_a", 1, 8'(i), 0, 0, 0, 0, 0, i + 1, 1, 8'h00, 0, 0, 0, 0);
        add("push_full", 1, 8'hAA, 0, 0, 0, 0, 0, 16, 1, 8'h00, 0, 1, 0, 0);
        for (int k = 0; k < 16; k++)
            add("drain_a", 0, 0, 0, 1, 0, 0, 0, 15 - k, 1, (k < 15) ? 8'(k + 1) : 8'h0F, 0, 1, 0, 0);
        add("clr_ovf", 0, 0, 0, 0, 0, 1, 0, 0, 1, 8'h0F, 0, 0, 0, 0);
        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++)
            add("fill_b", 1, 8'(i), 0, 0, 0, 0, 0, i + 1, 1, 8'h00, 0, 0, 0, 0);
        add("full_pushpop", 1, 8'h55, 0, 1, 0, 0, 0, 16, 1, 8'h01, 0, 0, 0, 0);
        for (int k = 0; k < 16; k++)
            add("drain_b", 0, 0, 0, 1, 0, 0, 0, 15 - k, 1, (k < 14) ? 8'(k + 2) : 8'h55, 0, 0, 0, 0);
        // Underflow, error bit, clear-vs-event priority, push+pop on empty.
        add("pop_empty",   0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h55, 0, 0, 1, 0);
        add("push_err",    1, 8'h7E, 1, 0, 0, 0, 0, 1, 1, 8'h7E, 1, 0, 1, 0);
        add("pop_clr",     0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 8'h7E, 1, 0, 0, 0);
        add("unf_clr_win", 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 1, 0);
        add("empty_pp",    1, 8'h33, 0, 1, 0, 0, 0, 1, 1, 8'h33, 0, 0, 1, 0);
        add("clr_unf",     0, 8'h00, 0, 0, 0, 1, 0, 1, 1, 8'h33, 0, 0, 0, 0);
        add("pop_33",      0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 8'h33, 0, 0, 0, 0);
        // Threshold interrupt.
        add("thr4_p1", 1, 8'h60, 0, 0, 0, 0, 4, 1, 1, 8'h60, 0, 0, 0, 0);
        add("thr4_p2", 1, 8'h61, 0, 0, 0, 0, 4, 2, 1, 8'h60, 0, 0, 0, 0);
        add("thr4_p3", 1, 8'h62, 0, 0, 0, 0, 4, 3, 1, 8'h60, 0, 0, 0, 0);
        add("thr4_p4", 1, 8'h63, 0, 0, 0, 0, 4, 4, 1, 8'h60, 0, 0, 0, 1);
        add("thr4_pop", 0, 8'h00, 0, 1, 0, 0, 4, 3, 1, 8'h61, 0, 0, 0, 0);
        add("thr3_idle", 0, 8'h00, 0, 0, 0, 0, 3, 3, 1, 8'h61, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++)
            add("thr0_fill", 1, 8'(8'h64 + i), 0, 0, 0, 0, 0, 4 + i, 1, 8'h61, 0, 0, 0, 0);
        add("thr17", 0, 8'h00, 0, 0, 0, 0, 17, 10, 1, 8'h61, 0, 0, 0, 0);
        add("thr10", 0, 8'h00, 0, 0, 0, 0, 10, 10, 1, 8'h61, 0, 0, 0, 1);
        add("thr11", 0, 8'h00, 0, 0, 0, 0, 11, 10, 1, 8'h61, 0, 0, 0, 0);
        // Flush, overflow beats clear, pointer wrap, flush with push.
        add("flush1", 0, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'h61, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            add("fill_c", 1, 8'(8'h80 + i), 0, 0, 0, 0, 0, i + 1, 1, 8'h80, 0, 0, 0, 0);
        add("ovf_clr_win", 1, 8'hEE, 0, 0, 0, 1, 0, 16, 1, 8'h80, 0, 1, 0, 0);
        for (int k = 0; k < 7; k++)
            add("pop_c", 0, 8'h00, 0, 1, 0, 0, 0, 15 - k, 1, 8'(8'h81 + k), 0, 1, 0, 0);
        add("wrap_pp0", 1, 8'hA0, 0, 1, 0, 0, 0, 9, 1, 8'h88, 0, 1, 0, 0);
        add("wrap_pp1", 1, 8'hA1, 0, 1, 0, 0, 0, 9, 1, 8'h89, 0, 1, 0, 0);
        add("flush_push", 1, 8'hC3, 0, 0, 1, 0, 0, 0, 1, 8'h89, 0, 1, 0, 0);
        add("post_flush0", 1, 8'hB0, 0, 0, 0, 0, 1, 1, 1, 8'hB0, 0, 1, 0, 1);
        add("post_flush1", 1, 8'hB1, 0, 0, 0, 0, 1, 2, 1, 8'hB0, 0, 1, 0, 1);

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("reset");

        foreach (vq[i]) apply(vq[i]);

        // Asynchronous reset between edges clears everything at once.
        idle_inputs();
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;
        apply('{nm: "after_reset", d: 1, dat: 8'hD0, er: 0, p: 0, fl: 0, cl: 0, thr: 0,
                lvl: 1, chk: 1, edat: 8'hD0, eerr: 0, ovf: 0, unf: 0, eirq: 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer between the UART receiver and the APB register interface.
- Captures each byte on the receiver's one-cycle done strobe, together with its per-byte error bit, into a first-word-fall-through FIFO.
- The bus side pops entries one at a time. The block exposes fill level, full/empty flags, sticky overflow/underflow flags and a programmable-threshold interrupt, so software no longer loses bytes that arrive between reads.

Parameters:
- DATAWIDTH, 8, width of one received character.
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- ADDRW, 4, log2(DEPTH); pointer width. The level counter is ADDRW+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_done  in  1  push strobe from receiver; one clk wide per character.
- rx_data  in  DATAWIDTH  character, valid when rx_done=1.
- rx_error  in  1  framing error for this character, valid when rx_done=1.
- pop  in  1  bus read strobe; removes the head entry.
- flush  in  1  synchronous clear of contents.
- clr_flags  in  1  synchronous clear of the sticky flags.
- thresh  in  ADDRW+1  interrupt threshold; 0 disables the interrupt.
- rd_data  out  DATAWIDTH  head-entry data.
- rd_error  out  1  head-entry error bit.
- empty  out  1  level==0.
- full  out  1  level==DEPTH.
- level  out  ADDRW+1  number of stored entries.
- overflow  out  1  sticky: a push was dropped.
- underflow  out  1  sticky: a pop was issued while empty.
- irq  out  1  registered; 1 when thresh!=0 and level>=thresh.

Behaviour:
- Reset (async, active-high):
  - wr_ptr=rd_ptr=0, level=0, empty=1, full=0, overflow=0, underflow=0, irq=0, rd_data=0, rd_error=0.
  - Storage contents are don't-care.
- Storage: DEPTH x (DATAWIDTH+1) array holding {rx_error, rx_data}. Pointers wrap modulo DEPTH by natural ADDRW-bit overflow.
- First-word-fall-through read:
  - rd_data/rd_error always reflect the entry at rd_ptr (registered output of the array read).
  - Valid whenever empty=0; hold the last value when empty.
  - After a push into an empty FIFO, data is visible and empty=0 on the next clk edge (1-cycle latency).
- Push: rx_done=1 and (full=0 or pop accepted in the same cycle) → write at wr_ptr, wr_ptr+1.
- Pop: pop=1 and empty=0 → rd_ptr+1; the next entry appears on rd_data the following cycle.
- Level update per cycle:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Registered; empty and full are derived from the registered level.
- Boundary conditions:
  - Full, push without pop: data dropped, overflow<=1, pointers unchanged.
  - Full, push and pop together: both accepted, level stays DEPTH, no overflow.
  - Empty, pop: ignored, underflow<=1. If a push occurs in the same cycle, the push is accepted and level becomes 1.
  - Empty, push and pop together: pop is not applied to the incoming byte.
- Flush=1:
  - Pointers and level go to 0 at the next edge.
  - Overrides push and pop in the same cycle; the push is discarded without setting overflow.
  - Sticky flags are unaffected.
- clr_flags=1: overflow and underflow go to 0. If an overflow or underflow event occurs in the same cycle, the event wins and the flag stays/becomes 1.
- irq:
  - Registered from the next-state level, so it updates in the same cycle as level.
  - thresh changes take effect at the next edge.
  - thresh>DEPTH means irq never asserts.
- Reset asserted mid-operation: all state returns to reset values immediately (async); no partial write survives.

Test Plan:
- Reset, then push 0x41, 0x42, 0x43 on three consecutive cycles → level=3, empty=0, rd_data=0x41. Three pops return 0x41, 0x42, 0x43 in order; then empty=1, level=0.
- Push 16 bytes 0x00..0x0F, then push 0xAA → full=1, overflow=1, level=16. Draining returns 0x00..0x0F; 0xAA is never seen. clr_flags → overflow=0.
- With the FIFO full, assert push 0x55 and pop together → level stays 16, overflow=0, head advances to 0x01. Draining ends with 0x55.
- Pop on empty → underflow=1, level stays 0. Push 0x7E with rx_error=1 → rd_data=0x7E, rd_error=1.
- thresh=4: push 3 bytes → irq=0; 4th push → irq=1 on the same edge level reaches 4; one pop → irq=0. thresh=0 with level=10 → irq=0.
- Fill to 9 entries, pointers wrapped past index 15. Assert flush together with rx_done → level=0, empty=1, overflow unchanged. Assert reset mid-stream → all outputs return to reset values immediately.
